fibonacci_lfsr_20_checker: RTL and testbench

Receive-side checker for the serial pseudorandom stream produced by the team's 20-bit Fibonacci LFSR generator (x^20 + x^17 + 1, taps at bits 19 and 16). It self-synchronises to the incoming bit stream and then free-runs a local replica of the LFSR. It reports lock, per-beat mismatches and a cumulative error count. It sits at the far end of stochastic-bitstream links and BIST paths to validate the generator and the channel.

---
 rtl/lfsr_pkg.sv | 12 +
 rtl/sat_counter.sv | 20 ++
 rtl/fibonacci_lfsr_20_checker.sv | 113 +++++++++++
 tb/tb_fibonacci_lfsr_20_checker.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared constants, state type and feedback helper for the 20-bit Fibonacci LFSR
package lfsr_pkg;
  localparam int LFSR20_WIDTH  = 20;
  localparam int LFSR20_TAP_HI = 19;
  localparam int LFSR20_TAP_LO = 16;

  typedef enum logic {SEARCH = 1'b0, LOCKED = 1'b1} chk_state_t;

  function automatic logic lfsr20_feedback(input logic [19:0] s);
    return s[LFSR20_TAP_HI] ^ s[LFSR20_TAP_LO];
  endfunction
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear taking priority over increment
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end
endmodule

// File: rtl/fibonacci_lfsr_20_checker.sv
// rtl/fibonacci_lfsr_20_checker.sv - self-synchronising checker for the x^20+x^17+1 serial stream
// Optional: FIBONACCI_LFSR_20_CHECKER_STATS_EN adds the beat_count output.
module fibonacci_lfsr_20_checker import lfsr_pkg::*; #(
  parameter int LOCK_COUNT = 32,
  parameter int WINDOW     = 64,
  parameter int LOSS_ERRS  = 8,
  parameter int CNT_W      = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             clr,
  output logic             locked,
  output logic             err,
`ifdef FIBONACCI_LFSR_20_CHECKER_STATS_EN
  output logic [CNT_W-1:0] beat_count,
`endif
  output logic [CNT_W-1:0] err_count
);
  localparam int FW = 5;
  localparam int MW = 8;
  localparam int WW = 8;
  localparam int EW = 9;

  chk_state_t              state;
  logic [LFSR20_WIDTH-1:0] hist;
  logic [FW-1:0]           fill;
  logic [MW-1:0]           match_cnt;
  logic [WW-1:0]           win_cnt;
  logic [EW-1:0]           win_errs;

  logic pred, mismatch, hist_zero, beat_lock, err_inc, loss;

  always_comb begin
    pred      = lfsr20_feedback(hist);
    mismatch  = bit_in ^ pred;
    hist_zero = (hist == '0);
    beat_lock = bit_valid && (state == LOCKED);
    err_inc   = beat_lock && mismatch;
    loss      = err_inc && (win_errs == EW'(LOSS_ERRS - 1));
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= SEARCH;
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
      win_cnt   <= '0;
      win_errs  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= 1'b0;
      if (bit_valid) begin
        if (state == SEARCH) begin
          hist <= {hist[LFSR20_WIDTH-2:0], bit_in};
          if (fill != FW'(LFSR20_WIDTH)) begin
            fill <= fill + FW'(1);
          end else if (mismatch) begin
            match_cnt <= '0;
          end else if (!hist_zero) begin
            // the all-zero history is a dead LFSR state, so its matches are ignored
            if (match_cnt == MW'(LOCK_COUNT - 1)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
              win_cnt   <= '0;
              win_errs  <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end
        end else begin
          // free-run the replica so a corrupted channel bit never enters the history
          hist <= {hist[LFSR20_WIDTH-2:0], pred};
          err  <= mismatch;
          if (loss) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            fill      <= '0;
            match_cnt <= '0;
          end else if (win_cnt == WW'(WINDOW - 1)) begin
            win_cnt  <= '0;
            win_errs <= '0;
          end else begin
            win_cnt  <= win_cnt + WW'(1);
            win_errs <= win_errs + EW'(mismatch);
          end
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_err_count (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (err_inc),
    .clr   (clr),
    .count (err_count)
  );

`ifdef FIBONACCI_LFSR_20_CHECKER_STATS_EN
  sat_counter #(.W(CNT_W)) u_beat_count (
    .clk   (CLK),
    .rst_n (nRST),
    .inc   (beat_lock),
    .clr   (clr),
    .count (beat_count)
  );
`endif
endmodule

// File: tb/tb_fibonacci_lfsr_20_checker.sv
// tb/tb_fibonacci_lfsr_20_checker.sv - randomized self-checking bench with a behavioural stream model
module tb_fibonacci_lfsr_20_checker;
  localparam int LOCK_COUNT = 32;
  localparam int WINDOW     = 64;
  localparam int LOSS_ERRS  = 8;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  logic bit_in = 1'b0;
  logic bit_valid = 1'b0;
  logic clr = 1'b0;
  logic locked, err, locked4, err4;
  logic [15:0] err_count;
  logic [3:0]  err_count4;
`ifdef FIBONACCI_LFSR_20_CHECKER_STATS_EN
  logic [15:0] beat_count;
  logic [3:0]  beat_count4;
`endif

  always #5 CLK = ~CLK;

  fibonacci_lfsr_20_checker dut (
    .CLK(CLK), .nRST(nRST), .bit_in(bit_in), .bit_valid(bit_valid), .clr(clr),
    .locked(locked), .err(err),
`ifdef FIBONACCI_LFSR_20_CHECKER_STATS_EN
    .beat_count(beat_count),
`endif
    .err_count(err_count)
  );

  fibonacci_lfsr_20_checker #(.CNT_W(4)) dut4 (
    .CLK(CLK), .nRST(nRST), .bit_in(bit_in), .bit_valid(bit_valid), .clr(clr),
    .locked(locked4), .err(err4),
`ifdef FIBONACCI_LFSR_20_CHECKER_STATS_EN
    .beat_count(beat_count4),
`endif
    .err_count(err_count4)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // stream model: line[] is the sequence the checker should hold as its history
  bit line[$];
  int n, search_start, run, lock_n, cur_w, werrs, exp_cnt, exp_beats;
  bit m_locked, exp_err;
  logic [19:0] gen_r;
  bit zero_mode = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int m;
    m = (1 << w) - 1;
    return (v > m) ? m : v;
  endfunction

  task automatic m_reset();
    line.delete();
    n = 0; search_start = 0; run = 0; lock_n = 0; cur_w = 0; werrs = 0;
    exp_cnt = 0; exp_beats = 0; m_locked = 1'b0; exp_err = 1'b0;
  endtask

  task automatic model_beat(input bit v, input bit b, input bit c);
    bit p, zero;
    int k;
    exp_err = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (n - search_start >= 20) begin
          p = line[n-20] ^ line[n-17];
          zero = 1'b1;
          for (int i = 1; i <= 20; i++) if (line[n-i]) zero = 1'b0;
          if (b != p) run = 0;
          else if (!zero) run++;
        end
        line.push_back(b);
        n++;
        if (run == LOCK_COUNT) begin
          m_locked = 1'b1; lock_n = n; cur_w = 0; werrs = 0;
        end
      end else begin
        p = line[n-20] ^ line[n-17];
        line.push_back(p);
        k = n - lock_n;
        n++;
        exp_beats++;
        if (k / WINDOW != cur_w) begin
          cur_w = k / WINDOW; werrs = 0;
        end
        if (b != p) begin
          exp_err = 1'b1; exp_cnt++; werrs++;
          if (werrs >= LOSS_ERRS) begin
            m_locked = 1'b0; search_start = n; run = 0;
          end
        end
      end
    end
    if (c) begin
      exp_cnt = 0; exp_beats = 0;
    end
  endtask

  task automatic beat(input bit v, input bit flip, input bit c);
    bit b;
    @(negedge CLK);
    if (v) begin
      b = zero_mode ? 1'b0 : (gen_r[0] ^ flip);
      gen_r = {gen_r[18:0], gen_r[19] ^ gen_r[16]};
    end else begin
      b = 1'($urandom_range(0, 1));
    end
    bit_valid = v; bit_in = b; clr = c;
    @(posedge CLK);
    #1;
    model_beat(v, b, c);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #2;
    nRST = 1'b0; chk_en = 1'b0; bit_valid = 1'b0; clr = 1'b0;
    #1;
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_err_count4", err_count4, 0);
    m_reset();
    #4;
    nRST = 1'b1; chk_en = 1'b1;
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      check("locked", locked, m_locked);
      check("err", err, exp_err);
      check("err_count", err_count, sat(exp_cnt, 16));
      check("locked4", locked4, m_locked);
      check("err4", err4, exp_err);
      check("err_count4", err_count4, sat(exp_cnt, 4));
`ifdef FIBONACCI_LFSR_20_CHECKER_STATS_EN
      check("beat_count", beat_count, sat(exp_beats, 16));
      check("beat_count4", beat_count4, sat(exp_beats, 4));
`endif
    end
  end

  initial begin
    int vb, locked_at, cnt, cyc;
    bit v, f, c;
    gen_r = 20'hDBEEF;
    m_reset();
    #12;
    check("init_locked", locked, 0);
    check("init_err", err, 0);
    check("init_err_count", err_count, 0);
    #1;
    nRST = 1'b1;
    chk_en = 1'b1;

    // clean lock
    vb = 0; locked_at = 0;
    for (int i = 0; i < 1000; i++) begin
      beat(1, 0, 0);
      vb++;
      if (locked === 1'b1 && locked_at == 0) locked_at = vb;
    end
    check("clean_lock_beats", locked_at, 52);
    check("model_lock_beats", lock_n, 52);
    check("clean_err_count", err_count, 0);

    // single error
    beat(1, 1, 0);
    for (int i = 0; i < 5; i++) beat(1, 0, 0);
    check("single_err_count", err_count, 1);
    check("single_locked", locked, 1);

    // loss of lock: 8 errors at the start of a window
    beat(1, 0, 1);
    cnt = 0;
    while (((n - lock_n) % WINDOW) != 0 && cnt < 200) begin beat(1, 0, 0); cnt++; end
    for (int i = 0; i < 8; i++) beat(1, 1, 0);
    check("loss_locked", locked, 0);
    check("loss_err_count", err_count, 8);
    cnt = 0;
    while (locked !== 1'b1 && cnt < 200) begin beat(1, 0, 0); cnt++; end
    check("relock_beats", cnt, 52);

    // window boundary: 7 at end of window N, 1 at start of N+1
    beat(1, 0, 1);
    cnt = 0;
    while (((n - lock_n) % WINDOW) != 57 && cnt < 200) begin beat(1, 0, 0); cnt++; end
    for (int i = 0; i < 8; i++) beat(1, 1, 0);
    for (int i = 0; i < 4; i++) beat(1, 0, 0);
    check("window_locked", locked, 1);
    check("window_err_count", err_count, 8);

    // saturation and clr priority
    beat(1, 0, 1);
    for (int i = 0; i < 20; i++) begin
      beat(1, 1, 0);
      for (int j = 0; j < 9; j++) beat(1, 0, 0);
    end
    check("sat_err_count4", err_count4, 15);
    check("sat_err_count", err_count, 20);
    beat(1, 1, 1);
    check("clr_prio_err_count", err_count, 0);
    check("clr_prio_err_count4", err_count4, 0);

    // async reset mid-window, then lock with 50% gaps
    beat(1, 1, 0);
    for (int i = 0; i < 10; i++) beat(1, 0, 0);
    do_reset();
    vb = 0; cyc = 0;
    while (locked !== 1'b1 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      beat(v, 0, 0);
      if (v) vb++;
      cyc++;
    end
    check("gap_lock_beats", vb, 52);

    // randomized traffic with gaps, sparse errors and occasional clr
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0);
      f = v && ($urandom_range(0, 99) < 3);
      c = ($urandom_range(0, 299) == 0);
      beat(v, f, c);
    end

    // all-zero stream never locks
    do_reset();
    zero_mode = 1'b1;
    for (int i = 0; i < 300; i++) beat(1, 0, 0);
    check("zero_locked", locked, 0);
    zero_mode = 1'b0;

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
